// File: rtl/count_gate_ctrl.sv
// Gate-window controller for an external pulse counter: clear, gate for N cycles, capture, hold.
// Latency: result_valid rises gate_len+2 cycles after the edge that accepts start.
// Backpressure: the result is held in HOLD until result_ready (or abort); start is ignored while busy.
module count_gate_ctrl #(
   parameter int CNT_W  = 16,
   parameter int GATE_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [GATE_W-1:0] gate_len,
   input  logic [CNT_W-1:0]  count_in,
   output logic              en_count,
   output logic              busy,
   output logic [CNT_W-1:0]  result,
   output logic              overflow,
   output logic              result_valid,
   input  logic              result_ready
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_GATE    = 3'd2,
      S_CAPTURE = 3'd3,
      S_HOLD    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0]    cnt_prev_q;
   logic [CNT_W-1:0]    result_q, result_d;
   logic                ovf_q, ovf_d;
   logic                valid_q, valid_d;
   logic                en_q, en_d;
   logic                wrap;

   // An all-ones count followed by zero means the external counter rolled over.
   assign wrap = (cnt_prev_q == {CNT_W{1'b1}}) && (count_in == {CNT_W{1'b0}});

   // Next-state, gate down-counter, capture and sticky overflow.
   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      result_d   = result_q;
      ovf_d      = ovf_q;
      valid_d    = valid_q;
      case (state_q)
         S_IDLE: begin
            // Abort wins over a simultaneous start; a zero-length gate is meaningless.
            if (!abort && start && (gate_len != {GATE_W{1'b0}})) begin
               state_d    = S_CLEAR;
               gate_cnt_d = gate_len;
               ovf_d      = 1'b0;
            end
         end
         S_CLEAR: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_GATE;
            end
         end
         S_GATE: begin
            if (wrap) begin
               ovf_d = 1'b1;
            end
            // Counts down from the latched length and stops at 1, so the full
            // range up to all-ones is usable without the counter wrapping.
            if (abort) begin
               state_d    = S_IDLE;
               gate_cnt_d = {GATE_W{1'b0}};
            end else if (gate_cnt_q == GATE_W'(1)) begin
               state_d    = S_CAPTURE;
               gate_cnt_d = {GATE_W{1'b0}};
            end else begin
               gate_cnt_d = gate_cnt_q - GATE_W'(1);
            end
         end
         S_CAPTURE: begin
            if (wrap) begin
               ovf_d = 1'b1;
            end
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               state_d  = S_HOLD;
               result_d = count_in;
               valid_d  = 1'b1;
            end
         end
         S_HOLD: begin
            if (abort || result_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
      // The counter enable is registered and follows the state being entered.
      en_d = (state_d == S_GATE);
   end

   // State and datapath registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         gate_cnt_q <= {GATE_W{1'b0}};
         cnt_prev_q <= {CNT_W{1'b0}};
         result_q   <= {CNT_W{1'b0}};
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         cnt_prev_q <= count_in;
         result_q   <= result_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
         en_q       <= en_d;
      end
   end

   assign en_count     = en_q;
   assign busy         = (state_q != S_IDLE);
   assign result       = result_q;
   assign overflow     = ovf_q;
   assign result_valid = valid_q;

endmodule

// File: tb/tb_count_gate_ctrl.sv
// Bench for count_gate_ctrl: a pulse-counter model plus expectations derived from cycle
// offsets after the start edge (cycle 0 = clear, 1..N = gate, N+1 = capture, N+2 = valid).
module tb_count_gate_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] gate_len = '0;
   logic [15:0] count_in;
   logic        en_count, busy, overflow, result_valid;
   logic [15:0] result;
   logic        result_ready = 1'b0;

   // Small instance used only to exercise the largest gate length.
   logic        s_start = 1'b0;
   logic [3:0]  s_gate = '0;
   logic [7:0]  s_cnt = '0;
   logic        s_en, s_busy, s_ovf, s_vld;
   logic [7:0]  s_res;

   int total = 0;
   int bad = 0;

   bit          pat [0:63];
   logic        pulse = 1'b0;
   logic        drive_direct = 1'b0;
   logic [15:0] direct_val = '0;
   logic [15:0] pc_q;
   logic [15:0] last_exp = '0;

   always #5 clk = ~clk;

   count_gate_ctrl #(.CNT_W(16), .GATE_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_len(gate_len),
      .count_in(count_in), .en_count(en_count), .busy(busy), .result(result),
      .overflow(overflow), .result_valid(result_valid), .result_ready(result_ready)
   );

   count_gate_ctrl #(.CNT_W(8), .GATE_W(4)) dut_small (
      .clk(clk), .rst(rst), .start(s_start), .abort(1'b0), .gate_len(s_gate),
      .count_in(s_cnt), .en_count(s_en), .busy(s_busy), .result(s_res),
      .overflow(s_ovf), .result_valid(s_vld), .result_ready(1'b1)
   );

   // Downstream pulse counter: counts while enabled, cleared when not.
   always @(posedge clk or posedge rst) begin
      if (rst) pc_q <= '0;
      else if (en_count) pc_q <= pc_q + {15'd0, pulse};
      else pc_q <= '0;
   end
   assign count_in = drive_direct ? direct_val : pc_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      total++; if ({en_count, busy, overflow, result_valid} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {en_count, busy, overflow, result_valid}); end
      total++; if (result !== 16'h0) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
      #10 rst = 1'b0;
      tick();
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
   endtask

   // Full measurement using pulse pattern pat[]; rdly cycles of backpressure in HOLD.
   task automatic run_measure(input int n, input int rdly, input bit poke_start, input string name);
      int en_hi;
      int early;
      int unstable;
      logic [15:0] exp;
      en_hi = 0; early = 0; unstable = 0; exp = '0;
      gate_len = n;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c <= n + 1; c++) begin
         if (en_count === 1'b1) en_hi++;
         if (result_valid !== 1'b0 || busy !== 1'b1) early++;
         pulse = pat[c];
         if (c >= 1 && c <= n && pat[c]) exp = exp + 16'd1;
         tick();
      end
      pulse = 1'b0;
      total++; if (en_hi != n) begin bad++; $display("FAIL %s en_cycles got=%0d want=%0d", name, en_hi, n); end
      total++; if (early != 0) begin bad++; $display("FAIL %s pre_valid got=%0d bad cycles want=0", name, early); end
      total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL %s valid_latency got=%b want=1", name, result_valid); end
      total++; if (result !== exp) begin bad++; $display("FAIL %s result got=%h want=%h", name, result, exp); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL %s overflow got=%b want=0", name, overflow); end
      for (int d = 0; d < rdly; d++) begin
         start = (poke_start && d == rdly / 2);
         tick();
         if (result_valid !== 1'b1 || result !== exp || busy !== 1'b1) unstable++;
      end
      start = 1'b0;
      if (rdly > 0) begin
         total++; if (unstable != 0) begin bad++; $display("FAIL %s hold_stable got=%0d bad cycles want=0", name, unstable); end
      end
      result_ready = 1'b1;
      start = poke_start;
      tick();
      result_ready = 1'b0;
      start = 1'b0;
      total++; if ({result_valid, busy} !== 2'b00) begin bad++; $display("FAIL %s transfer got=%b want=00", name, {result_valid, busy}); end
      total++; if (result !== exp) begin bad++; $display("FAIL %s retain got=%h want=%h", name, result, exp); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s post_idle busy got=%b want=0", name, busy); end
      last_exp = exp;
   endtask

   task automatic clear_pat();
      for (int i = 0; i < 64; i++) pat[i] = 1'b0;
   endtask

   task automatic test_basic();
      clear_pat();
      pat[2] = 1'b1; pat[5] = 1'b1; pat[8] = 1'b1;
      pat[0] = 1'b1; pat[11] = 1'b1;   // outside the gate: must not count
      run_measure(10, 0, 1'b0, "basic");
   endtask

   task automatic test_zero_len();
      int seen;
      seen = 0;
      gate_len = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (busy !== 1'b0 || result_valid !== 1'b0) seen++;
         tick();
      end
      total++; if (seen != 0) begin bad++; $display("FAIL zero_len got=%0d busy/valid cycles want=0", seen); end
   endtask

   task automatic test_wrap();
      logic [15:0] vals [0:7];
      vals[0] = 16'h0000; vals[1] = 16'hFFFE; vals[2] = 16'hFFFF; vals[3] = 16'h0000;
      vals[4] = 16'h0001; vals[5] = 16'h0001; vals[6] = 16'h0001; vals[7] = 16'h0001;
      drive_direct = 1'b1;
      gate_len = 6;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c <= 7; c++) begin
         direct_val = vals[c];
         tick();
      end
      drive_direct = 1'b0;
      total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b want=1", result_valid); end
      total++; if (result !== 16'h0001) begin bad++; $display("FAIL wrap_result got=%h want=0001", result); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL wrap_overflow got=%b want=1", overflow); end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL wrap_transfer got=%b want=0", result_valid); end
      last_exp = 16'h0001;
      // Next measurement must start with overflow cleared.
      clear_pat();
      pat[1] = 1'b1;
      run_measure(2, 1, 1'b0, "after_wrap");
   endtask

   task automatic test_hold();
      clear_pat();
      pat[1] = 1'b1; pat[3] = 1'b1;
      run_measure(3, 20, 1'b1, "hold");
   endtask

   task automatic test_abort();
      int vseen;
      vseen = 0;
      gate_len = 10;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      total++; if (en_count !== 1'b1) begin bad++; $display("FAIL abort_pre en got=%b want=1", en_count); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++; if ({en_count, busy} !== 2'b00) begin bad++; $display("FAIL abort_gate got=%b want=00", {en_count, busy}); end
      for (int c = 0; c < 15; c++) begin
         if (result_valid !== 1'b0) vseen++;
         tick();
      end
      total++; if (vseen != 0) begin bad++; $display("FAIL abort_novalid got=%0d want=0", vseen); end
      total++; if (result !== last_exp) begin bad++; $display("FAIL abort_result got=%h want=%h", result, last_exp); end
      // Abort beats result_ready in HOLD.
      gate_len = 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL abort_hold_pre got=%b want=1", result_valid); end
      abort = 1'b1;
      result_ready = 1'b1;
      tick();
      abort = 1'b0;
      result_ready = 1'b0;
      total++; if ({result_valid, busy} !== 2'b00) begin bad++; $display("FAIL abort_hold got=%b want=00", {result_valid, busy}); end
      // Abort and start together in IDLE: start is dropped.
      gate_len = 5;
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_start got=%b want=0", busy); end
      tick();
   endtask

   task automatic test_mid_reset();
      gate_len = 10;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 3; c++) tick();
      #3 rst = 1'b1;
      #1;
      total++; if ({en_count, busy, overflow, result_valid} !== 4'b0) begin bad++; $display("FAIL midrst_flags got=%b want=0000", {en_count, busy, overflow, result_valid}); end
      total++; if (result !== 16'h0) begin bad++; $display("FAIL midrst_result got=%h want=0000", result); end
      #3 rst = 1'b0;
      tick();
      clear_pat();
      pat[1] = 1'b1; pat[2] = 1'b1; pat[4] = 1'b1;
      run_measure(4, 2, 1'b0, "post_rst");
   endtask

   task automatic test_random();
      int n;
      int rd;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 30);
         rd = $urandom_range(0, 3);
         for (int i = 0; i < 64; i++) pat[i] = ($urandom_range(0, 1) == 1);
         run_measure(n, rd, 1'b0, "random");
      end
   endtask

   task automatic test_max_gate();
      int en_hi;
      en_hi = 0;
      s_gate = 4'hF;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int c = 0; c <= 16; c++) begin
         if (s_en === 1'b1) en_hi++;
         tick();
      end
      total++; if (en_hi != 15) begin bad++; $display("FAIL max_gate en_cycles got=%0d want=15", en_hi); end
      total++; if (s_vld !== 1'b1) begin bad++; $display("FAIL max_gate valid got=%b want=1", s_vld); end
      tick();
      total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL max_gate idle got=%b want=0", s_busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_wrap();
      test_hold();
      test_abort();
      test_mid_reset();
      test_random();
      test_max_gate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
